// File: rtl/alu_pkg.sv
// Shared constants, ALU op encodings, flag indices and FSM states for the ALU issue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int NREG   = 8;
   localparam int REG_AW = 3;
   localparam int FLAG_W = 5;

   // ALU operation codes; 1001..1111 are pass-through on the ALU side
   localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;  // B - A
   localparam logic [SEL_W-1:0] ALU_SLT  = 4'b0010;  // A < B
   localparam logic [SEL_W-1:0] ALU_SGT  = 4'b0011;  // A > B
   localparam logic [SEL_W-1:0] ALU_SLL1 = 4'b0100;
   localparam logic [SEL_W-1:0] ALU_SRL1 = 4'b0101;
   localparam logic [SEL_W-1:0] ALU_SRA1 = 4'b0110;
   localparam logic [SEL_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [SEL_W-1:0] ALU_OR   = 4'b1000;

   // Bit positions inside the 5-bit flag vector
   localparam int FLG_CARRY = 4;
   localparam int FLG_ZERO  = 3;
   localparam int FLG_NEG   = 2;
   localparam int FLG_OVF   = 1;
   localparam int FLG_UNF   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, preload, response and ALU-port bundle for alu_issue_ctrl.
// Latency: n/a (wiring only).
// Backpressure: cmd/ld/rsp are valid/ready; ALU ports are plain combinational wires.
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [SEL_W-1:0]    cmd_sel;
   logic [REG_AW-1:0]   cmd_rs1;
   logic [REG_AW-1:0]   cmd_rs2;
   logic [REG_AW-1:0]   cmd_rd;
   logic                cmd_imm_en;
   logic [DATA_W-1:0]   cmd_imm;

   logic                ld_valid;
   logic                ld_ready;
   logic [REG_AW-1:0]   ld_addr;
   logic [DATA_W-1:0]   ld_data;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_result;
   logic [FLAG_W-1:0]   rsp_flags;

   logic [SEL_W-1:0]    ALU_SEL;
   logic [DATA_W-1:0]   ALU_A;
   logic [DATA_W-1:0]   ALU_B;
   logic [DATA_W-1:0]   ALU_OUT;
   logic [FLAG_W-1:0]   ALU_FLAGS;

   // Front-end plus ALU side: offers commands/preloads, consumes responses, computes ALU results
   modport master (
      output cmd_valid, cmd_sel, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm_en, cmd_imm,
      output ld_valid, ld_addr, ld_data,
      output rsp_ready,
      output ALU_OUT, ALU_FLAGS,
      input  cmd_ready, ld_ready, rsp_valid, rsp_result, rsp_flags,
      input  ALU_SEL, ALU_A, ALU_B
   );

   // Controller side
   modport slave (
      input  cmd_valid, cmd_sel, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm_en, cmd_imm,
      input  ld_valid, ld_addr, ld_data,
      input  rsp_ready,
      input  ALU_OUT, ALU_FLAGS,
      output cmd_ready, ld_ready, rsp_valid, rsp_result, rsp_flags,
      output ALU_SEL, ALU_A, ALU_B
   );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one write port, r0 hardwired to zero.
// Latency: reads combinational; write visible on the cycle after the write edge.
// Backpressure: none, a write is always taken when i_we is high.
module alu_regfile
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_AW-1:0]   i_ra1,
   input  logic [REG_AW-1:0]   i_ra2,
   output logic [DATA_W-1:0]   o_rd1,
   output logic [DATA_W-1:0]   o_rd2,
   input  logic                i_we,
   input  logic [REG_AW-1:0]   i_wa,
   input  logic [DATA_W-1:0]   i_wd
);

   logic [DATA_W-1:0] r_mem [NREG];

   // Storage: async clear, writes to r0 dropped so r0 stays zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_we && (i_wa != '0)) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
   assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues register/immediate operand commands to a combinational ALU and returns captured result+flags.
// Latency: cmd accepted at edge k, ALU inputs registered at k, result/flags captured and rsp_valid high at k+1.
// Backpressure: cmd_ready/ld_ready low while a command is in flight; response held until rsp_ready.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   alu_issue_ctrl_if.slave bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SEL_W-1:0]    r_alu_sel;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [REG_AW-1:0]   r_rd;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_result;
   logic [FLAG_W-1:0]   r_rsp_flags;

   logic                w_cmd_rdy;
   logic                w_ld_rdy;
   logic                w_cmd_acc;
   logic                w_ld_acc;
   logic                w_issue;
   logic                w_wr_en;
   logic [REG_AW-1:0]   w_wr_addr;
   logic [DATA_W-1:0]   w_wr_dat;
   logic [DATA_W-1:0]   w_rs1_dat;
   logic [DATA_W-1:0]   w_rs2_dat;

   assign w_cmd_acc = bus.cmd_valid && w_cmd_rdy;
   assign w_ld_acc  = bus.ld_valid && w_ld_rdy;
   assign w_issue   = (r_state == ST_ISSUE);

   // Writeback (ISSUE only) and preload (IDLE only) share the single write port; they never overlap
   assign w_wr_en   = w_issue || w_ld_acc;
   assign w_wr_addr = w_issue ? r_rd : bus.ld_addr;
   assign w_wr_dat  = w_issue ? bus.ALU_OUT : bus.ld_data;

   alu_regfile u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ra1 (bus.cmd_rs1),
      .i_ra2 (bus.cmd_rs2),
      .o_rd1 (w_rs1_dat),
      .o_rd2 (w_rs2_dat),
      .i_we  (w_wr_en),
      .i_wa  (w_wr_addr),
      .i_wd  (w_wr_dat)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and ready outputs; both channels open only in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_rdy   = 1'b0;
      w_ld_rdy    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_rdy = 1'b1;
            w_ld_rdy  = 1'b1;
            if (bus.cmd_valid) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ALU drive registers: loaded on accept, otherwise hold last issued values; rs reads see pre-load data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_sel <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_rd      <= '0;
      end else if (w_cmd_acc) begin
         r_alu_sel <= bus.cmd_sel;
         r_alu_a   <= w_rs1_dat;
         r_alu_b   <= bus.cmd_imm_en ? bus.cmd_imm : w_rs2_dat;
         r_rd      <= bus.cmd_rd;
      end
   end

   // Response capture at the closing edge of ISSUE; valid drops on the response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
      end else if (w_issue) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_result <= bus.ALU_OUT;
         r_rsp_flags  <= bus.ALU_FLAGS;
      end else if (r_rsp_valid && bus.rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign bus.cmd_ready  = w_cmd_rdy;
   assign bus.ld_ready   = w_ld_rdy;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_flags  = r_rsp_flags;
   assign bus.ALU_SEL    = r_alu_sel;
   assign bus.ALU_A      = r_alu_a;
   assign bus.ALU_B      = r_alu_b;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and register-file model.
// Latency: checks result one edge after the ISSUE cycle starts and 3-cycle command spacing.
// Backpressure: exercises held responses with rsp_ready low and blocked cmd/ld channels.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] mreg [8];
   logic [31:0] res;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {carry, zero, neg, ovf, unf, result}
   function automatic logic [36:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] t;
      logic [31:0] r;
      logic c, n, o, u;
      c = 1'b0; n = 1'b0; o = 1'b0; u = 1'b0; t = '0;
      case (s)
         4'd0: begin
            t = {1'b0, a} + {1'b0, b};
            r = t[31:0];
            c = t[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
            u = t[32];
         end
         4'd1: begin
            t = {1'b0, b} + {1'b0, ~a} + 33'd1;
            r = t[31:0];
            c = t[32];
            n = ($signed(b) < $signed(a));
            o = (b[31] != a[31]) && (r[31] != b[31]);
         end
         4'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3: r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
         4'd4: r = a << 1;
         4'd5: r = a >> 1;
         4'd6: r = $signed(a) >>> 1;
         4'd7: r = a & b;
         4'd8: r = a | b;
         default: r = a;
      endcase
      return {c, (r == 32'd0), n, o, u, r};
   endfunction

   always_comb {bus.ALU_FLAGS, bus.ALU_OUT} = alu_f(bus.ALU_SEL, bus.ALU_A, bus.ALU_B);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Preload only; entered and left just after a negedge with the DUT in IDLE
   task automatic preload(input logic [2:0] la, input logic [31:0] ld);
      bus.ld_valid = 1'b1; bus.ld_addr = la; bus.ld_data = ld;
      chk("ld_ready_idle", 32'(bus.ld_ready), 32'd1);
      @(posedge clk);
      if (la != 3'd0) mreg[la] = ld;
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   // One command, optional same-cycle preload, optional response stall of 'hold' cycles.
   // During a stall a pending OR r3|r0 -> r6 is offered and left valid after the handshake.
   task automatic run_cmd(input logic [3:0] sel, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [2:0] rd, input logic imm_en, input logic [31:0] imm,
                          input logic ld_en, input logic [2:0] la, input logic [31:0] ld,
                          input int hold, output logic [31:0] result);
      logic [31:0] ea, eb;
      logic [36:0] ex;
      bus.cmd_valid = 1'b1; bus.cmd_sel = sel; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
      bus.cmd_rd = rd; bus.cmd_imm_en = imm_en; bus.cmd_imm = imm;
      bus.ld_valid = ld_en; bus.ld_addr = la; bus.ld_data = ld;
      chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      ea = mreg[rs1];
      eb = imm_en ? imm : mreg[rs2];
      ex = alu_f(sel, ea, eb);
      @(posedge clk);
      if (ld_en && la != 3'd0) mreg[la] = ld;
      @(negedge clk);
      bus.cmd_valid = 1'b0; bus.ld_valid = 1'b0;
      chk("issue_alu_sel", 32'(bus.ALU_SEL), 32'(sel));
      chk("issue_alu_a", bus.ALU_A, ea);
      chk("issue_alu_b", bus.ALU_B, eb);
      chk("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("issue_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (hold > 0) bus.rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("resp_result", bus.rsp_result, ex[31:0]);
      chk("resp_flags", 32'(bus.rsp_flags), 32'(ex[36:32]));
      if (rd != 3'd0) mreg[rd] = ex[31:0];
      for (int i = 0; i < hold; i++) begin
         bus.cmd_valid = 1'b1; bus.cmd_sel = ALU_OR; bus.cmd_rs1 = 3'd3; bus.cmd_rs2 = 3'd0;
         bus.cmd_rd = 3'd6; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0;
         bus.ld_valid = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = $urandom;
         @(posedge clk);
         @(negedge clk);
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_result", bus.rsp_result, ex[31:0]);
         chk("hold_flags", 32'(bus.rsp_flags), 32'(ex[36:32]));
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("hold_ld_ready", 32'(bus.ld_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1; bus.ld_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("post_alu_sel_hold", 32'(bus.ALU_SEL), 32'(sel));
      result = ex[31:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
      bus.cmd_rd = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0;
      bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.rsp_ready = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
      chk("rst_alu_sel", 32'(bus.ALU_SEL), 32'd0);
      chk("rst_alu_a", bus.ALU_A, 32'd0);
      chk("rst_alu_b", bus.ALU_B, 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ADD r1+r2 -> r3, then OR r3|r0
      preload(3'd1, 32'd5);
      preload(3'd2, 32'd3);
      run_cmd(ALU_ADD, 3'd1, 3'd2, 3'd3, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t1_add_const", res, 32'd8);
      run_cmd(ALU_OR, 3'd3, 3'd0, 3'd0, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t1_or_readback", res, 32'd8);

      // 2: SUB gives B-A
      run_cmd(ALU_SUB, 3'd1, 3'd2, 3'd0, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t2_sub_const", res, 32'hFFFF_FFFE);

      // 3: ADD with immediate into r0, r0 stays zero
      run_cmd(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFB, 1'b0, '0, '0, 0, res);
      chk("t3_add_imm_const", res, 32'd0);
      run_cmd(ALU_OR, 3'd0, 3'd0, 3'd0, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t3_r0_zero", res, 32'd0);

      // 4: stalled response, then the pending OR r3|r0 -> r6 is accepted
      run_cmd(ALU_ADD, 3'd1, 3'd2, 3'd7, 1'b0, '0, 1'b0, '0, '0, 5, res);
      run_cmd(ALU_OR, 3'd3, 3'd0, 3'd6, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t4_pending_cmd", res, 32'd8);

      // 5: same-cycle preload and command, no bypass
      run_cmd(ALU_ADD, 3'd1, 3'd2, 3'd4, 1'b0, '0, 1'b1, 3'd1, 32'd9, 0, res);
      chk("t5_old_r1", res, 32'd8);
      run_cmd(ALU_ADD, 3'd1, 3'd2, 3'd4, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t5_new_r1", res, 32'd12);

      // Randomised commands with random same-cycle preloads
      for (int i = 1; i < 8; i++) preload(3'(i), $urandom);
      for (int n = 0; n < 40; n++) begin
         run_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 0, res);
      end

      // 6: reset while a command with rd=5 is in ISSUE
      preload(3'd1, 32'h1234_5678);
      bus.cmd_valid = 1'b1; bus.cmd_sel = ALU_ADD; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd1;
      bus.cmd_rd = 3'd5; bus.cmd_imm_en = 1'b0;
      @(posedge clk);
      #2;
      bus.cmd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6_alu_sel", 32'(bus.ALU_SEL), 32'd0);
      chk("t6_alu_a", bus.ALU_A, 32'd0);
      chk("t6_alu_b", bus.ALU_B, 32'd0);
      chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_cmd_ready_rel", 32'(bus.cmd_ready), 32'd1);
      run_cmd(ALU_OR, 3'd5, 3'd0, 3'd0, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t6_r5_zero", res, 32'd0);
      run_cmd(ALU_OR, 3'd1, 3'd0, 3'd0, 1'b0, '0, 1'b0, '0, '0, 0, res);
      chk("t6_r1_zero", res, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
